// File: rtl/vga_board_renderer_pkg.sv
// Shared game-board definitions: tile codes, board size and the colour palette.
// Used by the renderer and by anything that talks to board_state.
package vga_board_renderer_pkg;

  localparam int BOARD_WIDTH  = 32;
  localparam int BOARD_LENGTH = 24;

  typedef enum logic [2:0] {
    EMPTY_BOX          = 3'd0,
    WALL_BOX           = 3'd1,
    FOOD_BOX           = 3'd2,
    PACMAN_BOX         = 3'd3,
    GHOST_BOX          = 3'd4,
    GHOST_AND_FOOD_BOX = 3'd5
  } tile_code_e;

  // RGB 3-3-2 palette
  localparam logic [7:0] RGB_BLACK     = 8'h00;
  localparam logic [7:0] RGB_WALL      = 8'h03;
  localparam logic [7:0] RGB_WALL_OVER = 8'hE0;
  localparam logic [7:0] RGB_FOOD      = 8'hFC;
  localparam logic [7:0] RGB_PACMAN    = 8'hFC;
  localparam logic [7:0] RGB_GHOST     = 8'hE3;
  localparam logic [7:0] RGB_GRID      = 8'h49;

  // Inclusive window test on an in-tile pixel offset
  function automatic logic in_range(input logic [5:0] val, input logic [5:0] lo,
                                    input logic [5:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_board_renderer_if.sv
// Board read port: the renderer drives the tile address (x,y) and board_state
// answers combinationally with the tile code in the same clock.
interface vga_board_renderer_if;

  logic [5:0] x;
  logic [5:0] y;
  logic [2:0] board_data;

  modport master (output x, output y, input board_data);
  modport slave  (input x, input y, output board_data);

endinterface

// File: rtl/vga_board_renderer_vga_timing.sv
// VGA raster timing: pixel-rate enable, h/v counters, raw syncs, active flag
// and a one-clock frame_tick at the start of vertical blank.
module vga_timing #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en,
  output logic line_end,
  output logic frame_end,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic active,
  output logic frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST   = 4'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0] div_cnt_r;
  logic [9:0] h_cnt_r;
  logic [9:0] v_cnt_r;
  logic       frame_tick_r;

  assign pix_en     = (div_cnt_r == DIV_LAST);
  assign line_end   = (h_cnt_r == H_LAST);
  assign frame_end  = (v_cnt_r == V_LAST);
  assign frame_tick = frame_tick_r;

  // Clock divider producing one pix_en per PIX_DIV clocks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= 4'd0;
    end else if (pix_en) begin
      div_cnt_r <= 4'd0;
    end else begin
      div_cnt_r <= div_cnt_r + 4'd1;
    end
  end

  // Horizontal/vertical raster counters, advanced once per pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (pix_en) begin
      if (line_end) begin
        h_cnt_r <= 10'd0;
        v_cnt_r <= frame_end ? 10'd0 : v_cnt_r + 10'd1;
      end else begin
        h_cnt_r <= h_cnt_r + 10'd1;
      end
    end
  end

  // Frame tick: high for the single clock in which the counters sit at (0, V_ACTIVE)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= pix_en && line_end && (v_cnt_r == V_ACT_LAST);
    end
  end

  // Raw (undelayed) syncs and active-area flag from the current counters
  always_comb begin
    hsync_raw = 1'b1;
    vsync_raw = 1'b1;
    active    = 1'b0;
    if ((h_cnt_r >= HS_START) && (h_cnt_r <= HS_END)) begin
      hsync_raw = 1'b0;
    end else begin
      hsync_raw = 1'b1;
    end
    if ((v_cnt_r >= VS_START) && (v_cnt_r <= VS_END)) begin
      vsync_raw = 1'b0;
    end else begin
      vsync_raw = 1'b1;
    end
    if ((h_cnt_r < H_ACT) && (v_cnt_r < V_ACT)) begin
      active = 1'b1;
    end else begin
      active = 1'b0;
    end
  end

endmodule

// File: rtl/vga_board_renderer.sv
// Tile-based VGA renderer for the 32x24 game board.
// Walks the board tile by tile (no dividers: per-tile pixel counters), reads
// each tile code through the board interface, and produces RGB 3-3-2 plus
// syncs through a two-stage pixel pipeline; syncs travel through the same
// two stages so they stay aligned with the colour.
// Optional build macro: PACMAN_GRID_EN draws a grey grid line on the first
// pixel column/row of every non-wall tile.
module vga_board_renderer
  import vga_board_renderer_pkg::*;
#(
  parameter int PIX_DIV  = 4,
  parameter int TILE_PX  = 20,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DOT_LO   = 8,
  parameter int DOT_HI   = 11,
  parameter int BOX_LO   = 2,
  parameter int BOX_HI   = 17
) (
  input  logic                        clk,
  input  logic                        reset,
  vga_board_renderer_if.master        board,
  input  logic                        game_over,
  output logic                        hsync,
  output logic                        vsync,
  output logic [7:0]                  rgb,
  output logic                        frame_tick
);

  localparam logic [5:0] TILE_LAST = 6'(TILE_PX - 1);
  localparam logic [5:0] COL_LAST  = 6'(BOARD_WIDTH - 1);
  localparam logic [5:0] ROW_TOP   = 6'(BOARD_LENGTH - 1);
  localparam logic [5:0] DOT_LO_C  = 6'(DOT_LO);
  localparam logic [5:0] DOT_HI_C  = 6'(DOT_HI);
  localparam logic [5:0] BOX_LO_C  = 6'(BOX_LO);
  localparam logic [5:0] BOX_HI_C  = 6'(BOX_HI);

  logic pix_en_s, line_end_s, frame_end_s;
  logic hsync_raw_s, vsync_raw_s, active_s;

  vga_timing #(
    .PIX_DIV (PIX_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en_s),
    .line_end  (line_end_s),
    .frame_end (frame_end_s),
    .hsync_raw (hsync_raw_s),
    .vsync_raw (vsync_raw_s),
    .active    (active_s),
    .frame_tick(frame_tick)
  );

  logic [5:0] col_px_r, row_px_r;
  logic [5:0] tile_col_r;
  logic [5:0] y_r;          // (BOARD_LENGTH-1) - tile_row, kept directly
  logic [2:0] s1_code_r;
  logic [5:0] s1_col_px_r, s1_row_px_r;
  logic       s1_active_r, s1_hs_r, s1_vs_r;
  logic [7:0] rgb_r;
  logic       hsync_r, vsync_r;
  logic [7:0] rgb_next_s;
  logic       grid_s, dot_s, box_s;

  assign board.x = tile_col_r;
  assign board.y = y_r;
  assign rgb     = rgb_r;
  assign hsync   = hsync_r;
  assign vsync   = vsync_r;

  // Column tracking: pixel-in-tile and tile column; column saturates at 31 in h-blank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_px_r   <= 6'd0;
      tile_col_r <= 6'd0;
    end else if (pix_en_s) begin
      if (line_end_s) begin
        col_px_r   <= 6'd0;
        tile_col_r <= 6'd0;
      end else if (col_px_r == TILE_LAST) begin
        col_px_r <= 6'd0;
        if (tile_col_r != COL_LAST) begin
          tile_col_r <= tile_col_r + 6'd1;
        end
      end else begin
        col_px_r <= col_px_r + 6'd1;
      end
    end
  end

  // Row tracking: line-in-tile and board row (counts down); row saturates at 0 in v-blank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_px_r <= 6'd0;
      y_r      <= ROW_TOP;
    end else if (pix_en_s && line_end_s) begin
      if (frame_end_s) begin
        row_px_r <= 6'd0;
        y_r      <= ROW_TOP;
      end else if (row_px_r == TILE_LAST) begin
        row_px_r <= 6'd0;
        if (y_r != 6'd0) begin
          y_r <= y_r - 6'd1;
        end
      end else begin
        row_px_r <= row_px_r + 6'd1;
      end
    end
  end

  // Stage 1: capture tile code with its pixel position, active flag and raw syncs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_code_r   <= 3'd0;
      s1_col_px_r <= 6'd0;
      s1_row_px_r <= 6'd0;
      s1_active_r <= 1'b0;
      s1_hs_r     <= 1'b1;
      s1_vs_r     <= 1'b1;
    end else if (pix_en_s) begin
      s1_code_r   <= board.board_data;
      s1_col_px_r <= col_px_r;
      s1_row_px_r <= row_px_r;
      s1_active_r <= active_s;
      s1_hs_r     <= hsync_raw_s;
      s1_vs_r     <= vsync_raw_s;
    end
  end

  // Colour decode of the stage-1 pixel; game_over is taken live here
  always_comb begin
    rgb_next_s = RGB_BLACK;
    grid_s     = 1'b0;
`ifdef PACMAN_GRID_EN
    grid_s     = (s1_col_px_r == 6'd0) || (s1_row_px_r == 6'd0);
`endif
    dot_s      = in_range(s1_col_px_r, DOT_LO_C, DOT_HI_C) &&
                 in_range(s1_row_px_r, DOT_LO_C, DOT_HI_C);
    box_s      = in_range(s1_col_px_r, BOX_LO_C, BOX_HI_C) &&
                 in_range(s1_row_px_r, BOX_LO_C, BOX_HI_C);
    if (!s1_active_r) begin
      rgb_next_s = RGB_BLACK;
    end else if (s1_code_r == WALL_BOX) begin
      rgb_next_s = game_over ? RGB_WALL_OVER : RGB_WALL;
    end else if (grid_s) begin
      rgb_next_s = RGB_GRID;
    end else begin
      case (tile_code_e'(s1_code_r))
        FOOD_BOX:           rgb_next_s = dot_s ? RGB_FOOD : RGB_BLACK;
        PACMAN_BOX:         rgb_next_s = box_s ? RGB_PACMAN : RGB_BLACK;
        GHOST_BOX:          rgb_next_s = box_s ? RGB_GHOST : RGB_BLACK;
        GHOST_AND_FOOD_BOX: rgb_next_s = box_s ? RGB_GHOST : RGB_BLACK;
        default:            rgb_next_s = RGB_BLACK;
      endcase
    end
  end

  // Stage 2: registered colour and syncs, two pixel ticks behind the counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r   <= 8'h00;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else if (pix_en_s) begin
      rgb_r   <= rgb_next_s;
      hsync_r <= s1_hs_r;
      vsync_r <= s1_vs_r;
    end
  end

endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed bench for vga_board_renderer on a shrunken raster (4-pixel tiles,
// short porches) so whole frames fit in the run. Every clock checks frame_tick;
// every pixel tick checks x, y, rgb, hsync and vsync against the bench's own
// raster/board model.
module tb_vga_board_renderer;
  import vga_board_renderer_pkg::*;

  localparam int PD  = 2;
  localparam int T   = 4;
  localparam int HA  = 128, HFP = 2, HSW = 4, HBP = 2;
  localparam int VA  = 96,  VFP = 1, VSW = 2, VBP = 1;
  localparam int HT  = HA + HFP + HSW + HBP;   // 136
  localparam int VT  = VA + VFP + VSW + VBP;   // 100
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       game_over = 1'b0;
  logic       hsync, vsync, frame_tick;
  logic [7:0] rgb;

  int vecs = 0;
  int miscompares = 0;
  int ecnt = 0;

  logic [2:0] board [0:31][0:23];

  vga_board_renderer_if bus();

  vga_board_renderer #(
    .PIX_DIV(PD), .TILE_PX(T),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .DOT_LO(2), .DOT_HI(2), .BOX_LO(1), .BOX_HI(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .board     (bus),
    .game_over (game_over),
    .hsync     (hsync),
    .vsync     (vsync),
    .rgb       (rgb),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // board_state model: combinational read of the addressed tile
  always_comb begin
    bus.board_data = 3'd0;
    if ((bus.x < 6'd32) && (bus.y < 6'd24)) begin
      bus.board_data = board[bus.x[4:0]][bus.y[4:0]];
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at clk %0d", tag, got, exp, ecnt);
    end
  endtask

  function automatic logic [7:0] exp_rgb(input int q, input logic go);
    int h, v, cp, rp;
    logic [2:0] code;
    h = q % HT;
    v = q / HT;
    if (h >= HA || v >= VA) return 8'h00;
    cp = h % T;
    rp = v % T;
    code = board[h / T][23 - v / T];
    if (code == 3'd1) return go ? 8'hE0 : 8'h03;
`ifdef PACMAN_GRID_EN
    if (cp == 0 || rp == 0) return 8'h49;
`endif
    case (code)
      3'd2:       return (cp == 2 && rp == 2) ? 8'hFC : 8'h00;
      3'd3:       return (cp >= 1 && cp <= 2 && rp >= 1 && rp <= 2) ? 8'hFC : 8'h00;
      3'd4, 3'd5: return (cp >= 1 && cp <= 2 && rp >= 1 && rp <= 2) ? 8'hE3 : 8'h00;
      default:    return 8'h00;
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, 8'(bus.x), 8'd0);
    check({tag, "_y"}, 8'(bus.y), 8'd23);
    check({tag, "_hsync"}, 8'(hsync), 8'd1);
    check({tag, "_vsync"}, 8'(vsync), 8'd1);
    check({tag, "_rgb"}, rgb, 8'h00);
    check({tag, "_frame_tick"}, 8'(frame_tick), 8'd0);
  endtask

  // One clock: frame_tick every clock, full pixel check on each pixel tick
  task automatic tick();
    int n, q, p, h, v;
    @(posedge clk);
    ecnt++;
    @(negedge clk);
    n = ecnt / PD;
    check("frame_tick", 8'(frame_tick),
          ((ecnt % PD == 0) && (n % FRAME == VA * HT)) ? 8'd1 : 8'd0);
    if (ecnt % PD == 0) begin
      q = n % FRAME;
      h = q % HT;
      v = q / HT;
      check("x", 8'(bus.x), (h < HA) ? 8'(h / T) : 8'd31);
      check("y", 8'(bus.y), (v < VA) ? 8'(23 - v / T) : 8'd0);
      if (n >= 2) begin
        p = (n - 2) % FRAME;
        h = p % HT;
        v = p / HT;
        check("rgb", rgb, exp_rgb(p, game_over));
        check("hsync", 8'(hsync), (h >= HA + HFP && h < HA + HFP + HSW) ? 8'd0 : 8'd1);
        check("vsync", 8'(vsync), (v >= VA + VFP && v < VA + VFP + VSW) ? 8'd0 : 8'd1);
      end else begin
        check("rgb_fill", rgb, 8'h00);
        check("hsync_fill", 8'(hsync), 8'd1);
        check("vsync_fill", 8'(vsync), 8'd1);
      end
    end
  endtask

  initial begin
    for (int bx = 0; bx < 32; bx++) begin
      for (int by = 0; by < 24; by++) begin
        board[bx][by] = (bx == 0 || bx == 31 || by == 0 || by == 23) ? 3'd1 : 3'd0;
      end
    end
    board[31][0]  = 3'd2;   // food in the bottom-right corner
    board[10][5]  = 3'd2;   // interior food
    board[1][1]   = 3'd3;   // pacman
    board[5][10]  = 3'd4;   // ghost
    board[6][10]  = 3'd5;   // ghost on food
    board[7][10]  = 3'd7;   // undefined code

    // Power-on reset
    #1 reset = 1'b1;
    #1 check_reset_values("por");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ecnt = 0;

    // Two full frames plus part of a third; palette flips mid-frame 0, back in frame 1
    for (int i = 0; i < PD * (2 * FRAME + 5 * HT + 126); i++) begin
      tick();
      if (ecnt == PD * (48 * HT + 2)) game_over = 1'b1;
      if (ecnt == PD * (FRAME + 10 * HT)) game_over = 1'b0;
    end

    // Mid-frame reset on line 5 while a wall pixel is on screen and x=31
    reset = 1'b1;
    #1 check_reset_values("midrst");
    repeat (3) begin
      @(negedge clk);
      check_reset_values("midrst_hold");
    end
    reset = 1'b0;
    ecnt = 0;

    // Scan restarts at (0,0); first frame_tick after VA lines
    for (int i = 0; i < PD * (VA * HT + 4); i++) begin
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
